// File: rtl/aix_fm_pkg.sv
// Shared constants, FSM encoding and length helper for the feature-map
// BRAM reader/writer pair.
package aix_fm_pkg;

  localparam int WI                 = 8;
  localparam int LANES              = 4;
  localparam int BRAM_DATA_WIDTH    = LANES * WI;
  localparam int BRAM_DATA_DEPTH    = 65536;
  localparam int BRAM_ADDRESS_WIDTH = $clog2(BRAM_DATA_DEPTH);
  localparam int MAX_FEATURE_SIZE   = 18;

  localparam int PROD_W  = 27;                    // 9b * 9b * 9b
  localparam int LEN_W   = MAX_FEATURE_SIZE + 1;  // holds 2^MAX_FEATURE_SIZE
  localparam int WORDS_W = LEN_W - 2;             // holds 2^MAX_FEATURE_SIZE / LANES
  localparam int MAX_LEN = 1 << MAX_FEATURE_SIZE;

  typedef enum logic [1:0] {
    FM_IDLE,
    FM_FETCH,
    FM_DRAIN,
    FM_DONE
  } fm_state_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [PROD_W-1:0] prod);
    if (prod > PROD_W'(MAX_LEN)) return LEN_W'(MAX_LEN);
    else return prod[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/word_unpacker.sv
// Two-word buffer (current + prefetch) that splits BRAM words into a
// valid/ready activation stream and tells the fetcher when a slot is free.
module word_unpacker
  import aix_fm_pkg::*;
(
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_vld,
  input  logic                       in_last,
  input  logic [BRAM_DATA_WIDTH-1:0] in_word,
  input  logic                       rd_issued,
  input  logic [2:0]                 last_lanes,
  input  logic                       ifm_rdy_i,
  output logic [WI-1:0]              ifm_data_o,
  output logic                       ifm_vld_o,
  output logic                       free_slot,
  output logic                       stream_done
);

  logic [LANES-1:0][WI-1:0] cur_word;
  logic [LANES-1:0][WI-1:0] pf_word;
  logic                     cur_vld;
  logic                     cur_last;
  logic                     pf_vld;
  logic                     pf_last;
  logic [1:0]               lane;

  logic       handshake;
  logic       word_pop;
  logic       cur_free;
  logic [2:0] lane_limit;
  logic [2:0] occupancy;

  // The last word of a transfer may carry fewer than LANES activations.
  assign lane_limit  = cur_last ? last_lanes : 3'(LANES);
  assign handshake   = cur_vld & ifm_rdy_i;
  assign word_pop    = handshake & ({1'b0, lane} == lane_limit - 3'd1);
  assign cur_free    = ~cur_vld | word_pop;
  assign stream_done = word_pop & cur_last;

  // Held words plus reads still travelling through the BRAM pipeline must
  // never exceed the two buffer slots.
  assign occupancy = {2'b0, cur_vld} + {2'b0, pf_vld} + {2'b0, in_vld} + {2'b0, rd_issued};
  assign free_slot = occupancy < (3'd2 + {2'b0, word_pop});

  assign ifm_data_o = cur_word[lane];
  assign ifm_vld_o  = cur_vld;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the data buffers are reset as well, because ifm_data_o is
      // read straight out of cur_word and must be zero while in reset.
      cur_word <= '0;
      pf_word  <= '0;
      cur_vld  <= 1'b0;
      cur_last <= 1'b0;
      pf_vld   <= 1'b0;
      pf_last  <= 1'b0;
      lane     <= '0;
    end else begin
      if (word_pop)       lane <= '0;
      else if (handshake) lane <= lane + 2'd1;

      if (cur_free) begin
        if (pf_vld) begin
          cur_word <= pf_word;
          cur_last <= pf_last;
          cur_vld  <= 1'b1;
          pf_vld   <= in_vld;
          if (in_vld) begin
            pf_word <= in_word;
            pf_last <= in_last;
          end
        end else begin
          cur_vld <= in_vld;
          if (in_vld) begin
            cur_word <= in_word;
            cur_last <= in_last;
          end
        end
      end else if (in_vld) begin
        pf_word <= in_word;
        pf_last <= in_last;
        pf_vld  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_feature_module.sv
// Reads a packed input feature map from BRAM and streams it one activation
// per cycle to the conv kernel; started and acknowledged via ap_start/ap_done.
module input_feature_module
  import aix_fm_pkg::*;
(
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          ap_start,
  input  logic [8:0]                    ifm_w,
  input  logic [8:0]                    in_ch,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] bram_base,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
  output logic                          bram_en,
  input  logic [BRAM_DATA_WIDTH-1:0]    bram_dout,
  output logic [WI-1:0]                 ifm_data_o,
  output logic                          ifm_vld_o,
  input  logic                          ifm_rdy_i,
  output logic                          ap_done
);

  fm_state_t state, state_nxt;

  logic [PROD_W-1:0]  prod;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   len_rnd;
  logic [WORDS_W-1:0] words_req;
  logic [WORDS_W-1:0] reads_left;
  logic [2:0]         last_lanes;

  logic issue;
  logic issue_last;
  logic en_last;
  logic rd_vld;
  logic vld_last;
  logic free_slot;
  logic stream_done;

  assign prod      = PROD_W'(ifm_w) * PROD_W'(ifm_w) * PROD_W'(in_ch);
  assign len       = clamp_len(prod);
  assign len_rnd   = len + LEN_W'(3);
  assign words_req = len_rnd[LEN_W-1:2];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_nxt  = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    unique case (state)
      FM_IDLE: begin
        if (ap_start) begin
          if (len == '0) begin
            state_nxt = FM_DONE;
          end else begin
            state_nxt  = FM_FETCH;
            issue      = 1'b1;
            issue_last = (words_req == WORDS_W'(1));
          end
        end
      end
      FM_FETCH: begin
        if (reads_left == '0) begin
          state_nxt = FM_DRAIN;
        end else if (free_slot) begin
          issue      = 1'b1;
          issue_last = (reads_left == WORDS_W'(1));
          if (issue_last) state_nxt = FM_DRAIN;
        end
      end
      FM_DRAIN: begin
        if (stream_done) state_nxt = FM_DONE;
      end
      FM_DONE: begin
        state_nxt = FM_IDLE;
      end
      default: begin
        state_nxt = FM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= FM_IDLE;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      reads_left <= '0;
      last_lanes <= 3'(LANES);
      en_last    <= 1'b0;
      rd_vld     <= 1'b0;
      vld_last   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bram_en  <= issue;
      en_last  <= issue_last;
      // BRAM data appears one cycle after the enable; tag it on the way.
      rd_vld   <= bram_en;
      vld_last <= en_last;

      if (issue) begin
        if (state == FM_IDLE) begin
          bram_addr  <= bram_base;
          reads_left <= words_req - WORDS_W'(1);
          last_lanes <= (len[1:0] == 2'd0) ? 3'(LANES) : {1'b0, len[1:0]};
        end else begin
          bram_addr  <= bram_addr + BRAM_ADDRESS_WIDTH'(1);
          reads_left <= reads_left - WORDS_W'(1);
        end
      end
    end
  end

  assign ap_done = (state == FM_DONE);

  word_unpacker u_word_unpacker (
    .clk         (clk),
    .rstn        (rstn),
    .in_vld      (rd_vld),
    .in_last     (vld_last),
    .in_word     (bram_dout),
    .rd_issued   (bram_en),
    .last_lanes  (last_lanes),
    .ifm_rdy_i   (ifm_rdy_i),
    .ifm_data_o  (ifm_data_o),
    .ifm_vld_o   (ifm_vld_o),
    .free_slot   (free_slot),
    .stream_done (stream_done)
  );

endmodule

// File: tb/tb_input_feature_module.sv
// Scoreboard bench: the stimulus side predicts addresses, bytes and ap_done
// from a BRAM image; a negedge monitor checks what the reader produces.
module tb_input_feature_module;
  import aix_fm_pkg::*;

  typedef struct {
    logic [WI-1:0] data;
    bit            last;
    bit            wend;
  } exp_t;

  logic                          clk = 1'b0;
  logic                          rstn;
  logic                          ap_start;
  logic [8:0]                    ifm_w;
  logic [8:0]                    in_ch;
  logic [BRAM_ADDRESS_WIDTH-1:0] bram_base;
  logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr;
  logic                          bram_en;
  logic [BRAM_DATA_WIDTH-1:0]    bram_dout;
  logic [WI-1:0]                 ifm_data_o;
  logic                          ifm_vld_o;
  logic                          ifm_rdy_i;
  logic                          ap_done;

  logic [BRAM_DATA_WIDTH-1:0] mem [BRAM_DATA_DEPTH];
  exp_t                          exp_q[$];
  logic [BRAM_ADDRESS_WIDTH-1:0] addr_q[$];

  int checks = 0;
  int failures = 0;
  int zero_starts = 0;
  int zero_seen = 0;
  int bytes_seen = 0;
  bit rdy_random = 1'b0;

  input_feature_module dut (
    .clk        (clk),
    .rstn       (rstn),
    .ap_start   (ap_start),
    .ifm_w      (ifm_w),
    .in_ch      (in_ch),
    .bram_base  (bram_base),
    .bram_addr  (bram_addr),
    .bram_en    (bram_en),
    .bram_dout  (bram_dout),
    .ifm_data_o (ifm_data_o),
    .ifm_vld_o  (ifm_vld_o),
    .ifm_rdy_i  (ifm_rdy_i),
    .ap_done    (ap_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en) bram_dout <= mem[bram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: stream index i is lane i%4 of word base + i/4.
  task automatic push_expect(input int w, input int ch, input int base, output int n);
    int nw;
    logic [BRAM_DATA_WIDTH-1:0] word;
    exp_t e;
    n = w * w * ch;
    if (n > MAX_LEN) n = MAX_LEN;
    nw = (n + LANES - 1) / LANES;
    for (int k = 0; k < nw; k++) addr_q.push_back(BRAM_ADDRESS_WIDTH'((base + k) % BRAM_DATA_DEPTH));
    for (int i = 0; i < n; i++) begin
      word   = mem[(base + i / LANES) % BRAM_DATA_DEPTH];
      e.data = word[WI * (i % LANES) +: WI];
      e.last = (i == n - 1);
      e.wend = (i % LANES == LANES - 1) || e.last;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_xfer(input int w, input int ch, input int base, input bit hold);
    int n;
    push_expect(w, ch, base, n);
    ifm_w     = 9'(w);
    in_ch     = 9'(ch);
    bram_base = BRAM_ADDRESS_WIDTH'(base);
    ap_start  = 1'b1;
    @(posedge clk); #1;
    if (!hold) ap_start = 1'b0;
    if (n == 0) zero_starts++;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      if (ap_done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // Ready driver: always 1, or a fair coin per cycle.
  initial begin
    ifm_rdy_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      ifm_rdy_i = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares everything the reader presents against the queues.
  initial begin
    bit            done_due = 1'b0;
    bit            exp_done;
    bit            prev_stall = 1'b0;
    logic [WI-1:0] prev_data = '0;
    int            ahead = 0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        done_due   = 1'b0;
        prev_stall = 1'b0;
        ahead      = 0;
      end else begin
        exp_done = done_due;
        done_due = 1'b0;
        if (zero_starts != zero_seen) begin
          exp_done = 1'b1;
          zero_seen++;
        end
        if (ap_done || exp_done) begin
          check("ap_done", 32'(ap_done), 32'(exp_done));
          check("vld_during_done", 32'(ifm_vld_o), 32'd0);
        end
        if (prev_stall) begin
          check("stall_vld_held", 32'(ifm_vld_o), 32'd1);
          check("stall_data_held", 32'(ifm_data_o), 32'(prev_data));
        end
        if (bram_en) begin
          if (addr_q.size() == 0) check("unexpected_read", 32'(bram_addr), 32'hffff_ffff);
          else check("bram_addr", 32'(bram_addr), 32'(addr_q.pop_front()));
          ahead++;
          check("read_ahead_le_2", 32'(ahead <= 2), 32'd1);
        end
        if (ifm_vld_o && ifm_rdy_i) begin
          bytes_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 32'(ifm_data_o), 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            check("ifm_data", 32'(ifm_data_o), 32'(e.data));
            if (e.wend) ahead--;
            if (e.last) done_due = 1'b1;
          end
        end
        prev_stall = ifm_vld_o && !ifm_rdy_i;
        prev_data  = ifm_data_o;
      end
    end
  end

  initial begin
    int cnt, cyc, b0, n;
    bit seen;
    for (int k = 0; k < BRAM_DATA_DEPTH; k++) begin
      if (k < 128) mem[k] = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      else mem[k] = $urandom;
    end
    rstn = 1'b0; ap_start = 1'b0; ifm_w = '0; in_ch = '0; bram_base = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_bram_en", 32'(bram_en), 32'd0);
    check("rst_bram_addr", 32'(bram_addr), 32'd0);
    check("rst_vld", 32'(ifm_vld_o), 32'd0);
    check("rst_data", 32'(ifm_data_o), 32'd0);
    check("rst_done", 32'(ap_done), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // 8x8x8 with ready held: latency, no bubbles, done right after.
    start_xfer(8, 8, 0, 1'b0);
    check("first_en", 32'(bram_en), 32'd1);
    check("first_addr", 32'(bram_addr), 32'd0);
    @(posedge clk); #1;
    check("vld_after_e1", 32'(ifm_vld_o), 32'd0);
    @(posedge clk); #1;
    check("vld_after_e2", 32'(ifm_vld_o), 32'd1);
    cnt = 0; cyc = 0; seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (ap_done) begin
        seen = 1'b1;
        break;
      end
      if (ifm_vld_o) cnt++;
      cyc++;
      @(posedge clk); #1;
    end
    check("t1_done_seen", 32'(seen), 32'd1);
    check("t1_valid_cycles", 32'(cnt), 32'd512);
    check("t1_cycles_to_done", 32'(cyc), 32'd512);
    repeat (3) @(posedge clk); #1;

    // 3x3x1 at base 100: partial last word.
    start_xfer(3, 1, 100, 1'b0);
    wait_done("t2_done");
    repeat (3) @(posedge clk); #1;

    // Zero-length map: no BRAM access, done right after start.
    start_xfer(0, 5, 10, 1'b0);
    check("zero_done", 32'(ap_done), 32'd1);
    check("zero_no_en", 32'(bram_en), 32'd0);
    repeat (3) @(posedge clk); #1;

    // Random ready stalls on the full map.
    rdy_random = 1'b1;
    start_xfer(8, 8, 0, 1'b0);
    wait_done("t4_done");
    repeat (3) @(posedge clk); #1;

    // Address wrap across the top of the BRAM.
    start_xfer(3, 2, 65534, 1'b0);
    wait_done("wrap_done");
    repeat (3) @(posedge clk); #1;

    // ap_start held high: back-to-back transfers, each started from IDLE.
    push_expect(3, 1, 200, n);
    start_xfer(3, 1, 200, 1'b1);
    wait_done("held_done1");
    @(posedge clk); #1;
    check("held_idle_gap", 32'(bram_en), 32'd0);
    @(posedge clk); #1;
    check("held_restart_en", 32'(bram_en), 32'd1);
    check("held_restart_addr", 32'(bram_addr), 32'd200);
    wait_done("held_done2");
    ap_start = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Reset after 100 bytes, then a clean full transfer.
    rdy_random = 1'b0;
    b0 = bytes_seen;
    start_xfer(8, 8, 0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (bytes_seen - b0 >= 100) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reached_100_bytes", 32'(seen), 32'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_en", 32'(bram_en), 32'd0);
    check("mid_rst_addr", 32'(bram_addr), 32'd0);
    check("mid_rst_vld", 32'(ifm_vld_o), 32'd0);
    check("mid_rst_data", 32'(ifm_data_o), 32'd0);
    check("mid_rst_done", 32'(ap_done), 32'd0);
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (8) @(posedge clk); #1;
    rdy_random = 1'b1;
    start_xfer(8, 8, 0, 1'b0);
    wait_done("post_rst_done");
    repeat (3) @(posedge clk); #1;

    // A few random shapes and bases.
    for (int t = 0; t < 3; t++) begin
      start_xfer($urandom_range(1, 12), $urandom_range(1, 4), $urandom_range(0, BRAM_DATA_DEPTH - 1), 1'b0);
      wait_done("rand_done");
      repeat (3) @(posedge clk); #1;
    end

    check("bytes_left", 32'(exp_q.size()), 32'd0);
    check("reads_left", 32'(addr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/input_feature_module.md
Name: input_feature_module

Overview:
- Reader counterpart to the output feature writer.
- Fetches a packed input feature map from BRAM: 32-bit words, four WI-bit activations per word.
- Unpacks the words and streams one activation per cycle to the conv kernel over a valid/ready handshake.
- Started by an ap_start/ap_done pair from the layer controller.

Parameters:
- WI, 8: activation width in bits.
- BRAM_DATA_WIDTH, 32: BRAM word width; must equal 4*WI.
- BRAM_DATA_DEPTH, 65536: BRAM depth in words (64*64*64/4).
- BRAM_ADDRESS_WIDTH, $clog2(BRAM_DATA_DEPTH): BRAM address width.
- MAX_FEATURE_SIZE, 18: log2 of the maximum transfer length in activations.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- ap_start  in  1  start request, level-sampled in IDLE.
- ifm_w  in  9  feature map width = height.
- in_ch  in  9  input channel count.
- bram_base  in  BRAM_ADDRESS_WIDTH  word address of the first word.
- bram_addr  out  BRAM_ADDRESS_WIDTH  read address.
- bram_en  out  1  read enable.
- bram_dout  in  BRAM_DATA_WIDTH  read data, valid one cycle after bram_en.
- ifm_data_o  out  WI  activation.
- ifm_vld_o  out  1  activation valid.
- ifm_rdy_i  in  1  kernel ready.
- ap_done  out  1  one-cycle completion pulse.
- Clock and reset: single clock clk; reset rstn is synchronous, active-low.

Behaviour:
- Reset (rstn=0 at a clk edge), also mid-transfer:
  - bram_addr=0, bram_en=0, ifm_data_o=0, ifm_vld_o=0, ap_done=0.
  - FSM returns to IDLE, all buffers are emptied, no ap_done is emitted.
- Length: N = ifm_w*ifm_w*in_ch.
  - Computed with a 27-bit product, latched at start.
  - Clamped to 2^MAX_FEATURE_SIZE.
  - Word count W = ceil(N/4).
- FSM states: IDLE, FETCH, DRAIN, DONE.
  - IDLE: ap_start=1 with N>0 latches ifm_w, in_ch and bram_base, then goes to FETCH. ap_start=1 with N=0 goes to DONE with no BRAM access.
  - FETCH: issues reads bram_base, bram_base+1, ... up to bram_base+W-1 (address wraps modulo 2^BRAM_ADDRESS_WIDTH). Goes to DRAIN after the last read is issued.
  - DRAIN: runs until the final byte is handshaken, then goes to DONE.
  - DONE: ap_done=1 for exactly one cycle, then IDLE.
  - ap_start is ignored outside IDLE. A level still high in IDLE starts a new transfer.
- Buffering:
  - Current-word register plus one prefetch word register.
  - bram_en is asserted only if, counting the read in flight, a slot will be free when the data returns. Read-ahead is at most 2 words.
  - bram_dout is captured unconditionally in the cycle after bram_en.
- Latency:
  - ap_start sampled at edge E0: bram_en=1 (addr=base) after E0, bram_dout valid after E1, ifm_vld_o=1 after E2.
  - With ifm_rdy_i held at 1, the stream has no bubbles: one byte per cycle, N consecutive cycles.
- Byte order: byte k of a word is bits [WI*k+WI-1 : WI*k], emitted k=0 first. Stream index i maps to word i/4, lane i%4.
- Handshake:
  - A transfer occurs when ifm_vld_o & ifm_rdy_i.
  - While ifm_vld_o=1 and ifm_rdy_i=0, ifm_data_o is held stable and ifm_vld_o stays 1.
  - ifm_vld_o never depends combinationally on ifm_rdy_i.
- Partial last word: if N%4 != 0, only N%4 lanes of word W-1 are emitted; the remaining lanes are discarded.
- ap_done is asserted the cycle after the handshake of byte N-1, with ifm_vld_o=0 in that cycle.

Decomposition:
- Package aix_fm_pkg:
  - WI, BRAM_DATA_WIDTH, BRAM_ADDRESS_WIDTH, MAX_FEATURE_SIZE, LANES=4.
  - FSM state encoding shared with output_feature_module.
- Sub-module word_unpacker:
  - Holds the current word and prefetch word, lane counter, valid/ready output and last-word lane limit.
  - Presents a free-slot signal to the fetch FSM.

Test Plan:
- ifm_w=8, in_ch=8, base=0, word k = {4k+3,4k+2,4k+1,4k} mod 256, rdy=1 → 128 reads at addr 0..127, 512 bytes 0..255,0..255 on consecutive cycles, first valid 2 edges after start, ap_done 1 cycle after last byte.
- ifm_w=3, in_ch=1, base=100 → 3 reads at addr 100..102, exactly 9 bytes, lanes 1..3 of the third word dropped, ap_done one pulse.
- ifm_w=0 (any in_ch) → no bram_en, ap_done one cycle after start.
- ifm_w=8, in_ch=8 with rdy toggled pseudo-randomly at 50% → identical 512-byte sequence, data stable while stalled, no more than 2 words read ahead.
- ap_start held high throughout a transfer → no restart mid-transfer; second transfer begins in IDLE right after ap_done.
- rstn=0 after 100 bytes → all outputs 0 next edge, no ap_done; restart gives a full correct 512-byte sequence.
